// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared constants, level count and round/saturate for fir_iq_stream
// Revision: 1.0
// ============================================================================
package fir_pkg;

    localparam int DEFAULT_LEN = 9;
    localparam logic [15:0] DEFAULT_COEF [DEFAULT_LEN] = '{
        16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
        16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
    };

    // Wide enough to hold any accumulator this block is parameterised for.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    sat;
    } round_sat_t;

    function automatic int num_levels(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic logic signed [31:0] default_coef(input int k);
        logic [15:0] c;
        c = '0;
        if (k >= 0 && k < DEFAULT_LEN) begin
            c = DEFAULT_COEF[k[3:0]];
        end
        return {{16{c[15]}}, c};
    endfunction

    function automatic round_sat_t round_sat(input logic signed [SAT_W-1:0] acc,
                                             input int                      dw,
                                             input int                      frac);
        round_sat_t              res;
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] half;
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] maxv;
        logic signed [SAT_W-1:0] minv;
        one  = SAT_W'(1);
        half = (frac > 0) ? (one <<< (frac - 1)) : '0;
        r    = (acc + half) >>> frac;
        maxv = (one <<< (dw - 1)) - one;
        minv = ~maxv;
        res.value = r;
        res.sat   = 1'b0;
        if (r > maxv) begin
            res.value = maxv;
            res.sat   = 1'b1;
        end else if (r < minv) begin
            res.value = minv;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_adder_tree.sv
`default_nettype none
// ============================================================================
// fir_adder_tree : registered binary adder tree, one level per clock
// Revision: 1.0
// ============================================================================
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N  = 9,
    parameter int IW = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [N*IW-1:0]             in_data,
    output logic                        out_valid,
    output logic [IW+num_levels(N)-1:0] out_data
);

    localparam int NL = num_levels(N);

    function automatic int cnt_at(input int lvl);
        return (N + (1 << lvl) - 1) >> lvl;
    endfunction

    for (genvar l = 1; l <= NL; l++) begin : g_lvl
        localparam int W  = IW + l;
        localparam int WP = W - 1;
        localparam int CN = cnt_at(l);
        localparam int CP = cnt_at(l - 1);

        logic [CP*WP-1:0] prev;
        logic             prev_valid;
        logic [CN*W-1:0]  data;
        logic             valid;

        if (l == 1) begin : g_first
            assign prev       = in_data;
            assign prev_valid = in_valid;
        end else begin : g_rest
            assign prev       = g_lvl[l-1].data;
            assign prev_valid = g_lvl[l-1].valid;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid <= 1'b0;
            end else begin
                valid <= prev_valid;
            end
        end

        for (genvar j = 0; j < CN; j++) begin : g_node
            logic signed [W-1:0] sum;

            // An unpaired last element is sign-extended and carried up a level.
            if (2*j + 1 < CP) begin : g_pair
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sum <= '0;
                    end else begin
                        sum <= W'(signed'(prev[2*j*WP +: WP]))
                             + W'(signed'(prev[(2*j+1)*WP +: WP]));
                    end
                end
            end else begin : g_pass
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sum <= '0;
                    end else begin
                        sum <= W'(signed'(prev[2*j*WP +: WP]));
                    end
                end
            end

            assign data[j*W +: W] = sum;
        end
    end

    assign out_valid = g_lvl[NL].valid;
    assign out_data  = g_lvl[NL].data;

endmodule
`default_nettype wire

// File: rtl/fir_iq_stream.sv
`default_nettype none
// ============================================================================
// fir_iq_stream : pipelined complex FIR with valid handshake and reloadable taps
// Revision: 1.0
// ============================================================================
module fir_iq_stream
    import fir_pkg::*;
#(
    parameter int TAPS = 9,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DW-1:0]            I_in,
    input  logic [DW-1:0]            Q_in,
    input  logic                     coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    input  logic                     coef_commit,
    output logic                     out_valid,
    output logic [DW-1:0]            Inphase_FIR,
    output logic [DW-1:0]            Qphase_FIR,
    output logic                     sat_I,
    output logic                     sat_Q
);

    localparam int NLVL = num_levels(TAPS);
    localparam int PW   = DW + CW;
    localparam int AW   = PW + NLVL;

    logic signed [CW-1:0] init_coef [TAPS];
    logic signed [CW-1:0] shadow    [TAPS];
    logic signed [CW-1:0] active    [TAPS];
    logic signed [DW-1:0] dl_i      [TAPS];
    logic signed [DW-1:0] dl_q      [TAPS];
    logic                 dl_valid;
    logic [TAPS*PW-1:0]   prod_i;
    logic [TAPS*PW-1:0]   prod_q;
    logic                 prod_valid;
    logic [AW-1:0]        acc_i;
    logic [AW-1:0]        acc_q;
    logic                 tree_valid_i;
    logic                 tree_valid_q;
    logic                 tree_valid;
    round_sat_t           rs_i;
    round_sat_t           rs_q;

    for (genvar k = 0; k < TAPS; k++) begin : g_init
        localparam logic signed [31:0] C32 = default_coef(k);
        assign init_coef[k] = CW'(C32);
    end

    // Commit samples the shadow bank before any same-cycle write lands in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= init_coef[k];
                active[k] <= init_coef[k];
            end
        end else begin
            if (coef_commit) begin
                for (int k = 0; k < TAPS; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (coef_wr_en && (32'(coef_addr) < 32'(TAPS))) begin
                shadow[coef_addr] <= coef_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dl_i[k] <= '0;
                dl_q[k] <= '0;
            end
        end else begin
            dl_valid <= in_valid;
            if (in_valid) begin
                dl_i[0] <= I_in;
                dl_q[0] <= Q_in;
                for (int k = 1; k < TAPS; k++) begin
                    dl_i[k] <= dl_i[k-1];
                    dl_q[k] <= dl_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_valid <= 1'b0;
            prod_i     <= '0;
            prod_q     <= '0;
        end else begin
            prod_valid <= dl_valid;
            for (int k = 0; k < TAPS; k++) begin
                prod_i[k*PW +: PW] <= PW'(dl_i[k]) * PW'(active[k]);
                prod_q[k*PW +: PW] <= PW'(dl_q[k]) * PW'(active[k]);
            end
        end
    end

    fir_adder_tree #(
        .N  (TAPS),
        .IW (PW)
    ) u_tree_i (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (prod_valid),
        .in_data   (prod_i),
        .out_valid (tree_valid_i),
        .out_data  (acc_i)
    );

    fir_adder_tree #(
        .N  (TAPS),
        .IW (PW)
    ) u_tree_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (prod_valid),
        .in_data   (prod_q),
        .out_valid (tree_valid_q),
        .out_data  (acc_q)
    );

    // Both trees see the same valid bit, so they advance in lockstep.
    assign tree_valid = tree_valid_i & tree_valid_q;
    assign rs_i       = round_sat(SAT_W'(signed'(acc_i)), DW, FRAC);
    assign rs_q       = round_sat(SAT_W'(signed'(acc_q)), DW, FRAC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            Inphase_FIR <= '0;
            Qphase_FIR  <= '0;
            sat_I       <= 1'b0;
            sat_Q       <= 1'b0;
        end else begin
            out_valid <= tree_valid;
            if (tree_valid) begin
                Inphase_FIR <= DW'(rs_i.value);
                Qphase_FIR  <= DW'(rs_q.value);
                sat_I       <= rs_i.sat;
                sat_Q       <= rs_q.sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fir_iq_stream.md
Name: fir_iq_stream

Overview:
- Parametrised, pipelined complex (I/Q) FIR filter; successor to the fixed 9-tap I/Q FIR.
- Adds a valid handshake with stall-free sample gaps and run-time reloadable coefficients (shadow/active banks).
- Adds round-half-up output quantisation with saturation and per-sample saturation flags.
- Sits between the I/Q sample source and the magnitude-calculation stage; one instance per filter channel.

Parameters:
- TAPS, 9, number of taps (2..128).
- DW, 16, I/Q sample and output width, signed.
- CW, 16, coefficient width, signed.
- FRAC, 15, coefficient fractional bits; output = accumulator >>> FRAC after rounding.

Ports:
- clk  in  1  sampling clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  I_in/Q_in carry a new sample this cycle.
- I_in  in  DW  in-phase sample, signed.
- Q_in  in  DW  quadrature sample, signed.
- coef_wr_en  in  1  write coef_data into shadow bank at coef_addr.
- coef_addr  in  $clog2(TAPS)  shadow tap index.
- coef_data  in  CW  coefficient value, signed.
- coef_commit  in  1  copy the whole shadow bank to the active bank.
- out_valid  out  1  filtered sample valid.
- Inphase_FIR  out  DW  filtered I, signed.
- Qphase_FIR  out  DW  filtered Q, signed.
- sat_I  out  1  Inphase_FIR was clipped this sample.
- sat_Q  out  1  Qphase_FIR was clipped this sample.

Behaviour:
- Reset (async assert, synchronous release):
  - delay lines, products, adder-tree registers, valid pipe, out_valid, outputs and sat flags all go to 0.
  - shadow and active banks load DEFAULT_COEF (taps beyond the default length load 0).
- Delay line:
  - shifts only when in_valid=1: tap0 <= input, tap k <= tap k-1.
  - with in_valid=0, taps hold and no output is produced.
- Pipeline:
  - stage 1 registers the delay line.
  - stage 2 multiplies each tap by its active coefficient (DW+CW bits).
  - then a binary adder tree, one level per cycle, NLVL=$clog2(TAPS) levels; odd element passes through; width grows 1 bit per level.
  - final stage rounds and saturates.
- Latency: LAT = 3+NLVL cycles from in_valid to out_valid (TAPS=9 gives 7).
  - A valid bit travels alongside the data.
  - The arithmetic pipeline always advances; bubbles carry out_valid=0.
- Throughput: one sample per cycle; any in_valid pattern is accepted (no backpressure).
- Output hold: outputs and sat flags update only with out_valid=1 and hold otherwise.
- Quantisation:
  - acc width AW=DW+CW+NLVL.
  - r = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift.
  - if r > 2^(DW-1)-1, output max and set sat; if r < -2^(DW-1), output min and set sat; else output r.
- Coefficient writes:
  - coef_wr_en writes shadow only; the active bank is unaffected.
  - coef_addr >= TAPS is ignored.
  - coef_commit copies shadow to active at the clock edge; products in the following cycle use the new set.
  - Samples already in the adder tree finish with the old set; there is no mixed-set product within a single cycle.
- Simultaneous events:
  - coef_wr_en with coef_commit in the same cycle: the commit copies the pre-write shadow; the write lands in shadow only.
  - Reset mid-stream: all in-flight samples are discarded, and out_valid stays 0 until LAT cycles after the first post-reset in_valid.
- Sat flags: pulse-per-sample, not sticky.

Decomposition:
- Package fir_pkg: DEFAULT_COEF array {04F6,0AE4,1089,1496,160F,1496,1089,0AE4,04F6} and its length constant; function clog2-based level count; the round-and-saturate function shared by both channels.
- Sub-module fir_adder_tree (params N, IW; registered levels, valid pass-through), instantiated once for I and once for Q.
- Coefficient banks and delay lines stay in the top level.

Test Plan:
- Impulse I_in=0x7FFF, Q_in=0x8000 for one valid cycle, default coefficients -> 9 consecutive out_valid samples, first at cycle 7.
  - Inphase_FIR = 04F6,0AE4,1089,1496,160F,1496,1089,0AE4,04F6.
  - Qphase_FIR = negation of each; sat flags 0.
- DC saturation: I_in=0x7FFF and Q_in=0x8000 held valid.
  - The default coefficients sum to 32769, so after the fill Inphase_FIR=0x7FFF with sat_I=1.
  - Qphase_FIR=0x8000 with sat_Q=1.
- Gapped input: the impulse test with in_valid randomly deasserted 50% of cycles -> identical output sequence; out_valid count equals in_valid count; outputs hold across gaps.
- Reload: write all taps 0 except tap4=0x4000, then commit; impulse I_in=0x4000 -> single nonzero output 0x2000, at the 5th out_valid after the impulse.
- Commit mid-stream: continuous ramp input, commit halfway -> every output matches the golden model using the bank active at that sample's multiply cycle; out-of-range coef_addr writes have no effect.
- Reset: assert rst_n=0 for 1 cycle during streaming -> all outputs 0 immediately; coefficients revert to default; first out_valid arrives 7 cycles after the first post-reset valid.
